// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types, default sizes and helpers for the sequential multiplier
package mult_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DIGIT = 4;

  // Number of digit slices needed to consume a full multiplier operand.
  function automatic int iter_count(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/mult_digit.sv
// rtl/mult_digit.sv - combinational WIDTH x DIGIT unsigned partial-product generator
module mult_digit
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIGIT = DEFAULT_DIGIT
) (
  input  logic [WIDTH-1:0]       a,
  input  logic [DIGIT-1:0]       b,
  output logic [WIDTH+DIGIT-1:0] p
);

  localparam int PW = WIDTH + DIGIT;

  // Both factors are widened first so the product keeps every carry bit.
  assign p = PW'(a) * PW'(b);

endmodule

// File: rtl/seq_mult.sv
// rtl/seq_mult.sv - multi-cycle unsigned multiplier, one DIGIT slice per clock; SEQ_MULT_FULL_PRODUCT_EN adds out_hi
module seq_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIGIT = DEFAULT_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
`ifdef SEQ_MULT_FULL_PRODUCT_EN
  output logic [WIDTH-1:0] out_hi,
`endif
  output logic             overflow
);

  localparam int ITER = iter_count(WIDTH, DIGIT);
  // Keep the counter at least one bit wide so ITER == 1 still elaborates.
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] K_LAST = CW'(ITER - 1);
  localparam int AW = 2 * WIDTH;

  state_t state, state_nxt;
  logic   load, step, finish;

  logic [WIDTH-1:0]       a_reg;
  logic [WIDTH-1:0]       b_reg;
  logic [CW-1:0]          k;
  logic [AW-1:0]          acc;
  logic [AW-1:0]          acc_next;
  logic [DIGIT-1:0]       b_digit;
  logic [WIDTH+DIGIT-1:0] pp;
  logic [AW-1:0]          pp_ext;

  logic             done_r;
  logic [WIDTH-1:0] out_r;
  logic             ovf_r;
`ifdef SEQ_MULT_FULL_PRODUCT_EN
  logic [WIDTH-1:0] out_hi_r;
`endif

  // b_reg is shifted right each step, so its low slice is always B[DIGIT*k +: DIGIT].
  assign b_digit = b_reg[DIGIT-1:0];

  mult_digit #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) u_digit (
    .a (a_reg),
    .b (b_digit),
    .p (pp)
  );

  assign pp_ext   = AW'(pp);
  assign acc_next = acc + (pp_ext << (DIGIT * k));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and per-cycle datapath controls.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (k == K_LAST) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture and shift-and-accumulate; operands are frozen while RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      k     <= '0;
    end else if (load) begin
      a_reg <= ina;
      b_reg <= inb;
      acc   <= '0;
      k     <= '0;
    end else if (step) begin
      acc   <= acc_next;
      b_reg <= b_reg >> DIGIT;
      k     <= finish ? '0 : k + CW'(1);
    end
  end

  // Result registers: written only on the finishing edge, so they hold between operations.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_r   <= 1'b0;
      out_r    <= '0;
      ovf_r    <= 1'b0;
`ifdef SEQ_MULT_FULL_PRODUCT_EN
      out_hi_r <= '0;
`endif
    end else begin
      done_r <= finish;
      if (finish) begin
        out_r    <= acc_next[WIDTH-1:0];
        ovf_r    <= |acc_next[AW-1:WIDTH];
`ifdef SEQ_MULT_FULL_PRODUCT_EN
        out_hi_r <= acc_next[AW-1:WIDTH];
`endif
      end
    end
  end

  assign busy     = (state == RUN);
  assign done     = done_r;
  assign out      = out_r;
  assign overflow = ovf_r;
`ifdef SEQ_MULT_FULL_PRODUCT_EN
  assign out_hi   = out_hi_r;
`endif

endmodule

// File: tb/tb_seq_mult.sv
// tb/tb_seq_mult.sv - self-checking bench for seq_mult at 16/4 and 8/2 configurations
module tb_seq_mult;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start16 = 1'b0;
  logic [15:0] ina16 = '0, inb16 = '0, out16;
  logic        busy16, done16, ovf16;
  logic        start8 = 1'b0;
  logic [7:0]  ina8 = '0, inb8 = '0, out8;
  logic        busy8, done8, ovf8;
`ifdef SEQ_MULT_FULL_PRODUCT_EN
  logic [15:0] hi16;
  logic [7:0]  hi8;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_mult #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk      (clk),
    .rst      (rst),
    .start    (start16),
    .ina      (ina16),
    .inb      (inb16),
    .busy     (busy16),
    .done     (done16),
    .out      (out16),
`ifdef SEQ_MULT_FULL_PRODUCT_EN
    .out_hi   (hi16),
`endif
    .overflow (ovf16)
  );

  seq_mult #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clk      (clk),
    .rst      (rst),
    .start    (start8),
    .ina      (ina8),
    .inb      (inb8),
    .busy     (busy8),
    .done     (done8),
    .out      (out8),
`ifdef SEQ_MULT_FULL_PRODUCT_EN
    .out_hi   (hi8),
`endif
    .overflow (ovf8)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
    logic [15:0] hi;
    logic        ovf;
  } vec16_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;
    logic       ovf;
  } vec8_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Called at a falling edge; drives start for one cycle and returns cycles until done.
  task automatic run16(input logic [15:0] a, input logic [15:0] b, output int lat);
    start16 = 1'b1; ina16 = a; inb16 = b;
    @(negedge clk);
    start16 = 1'b0; ina16 = 16'($urandom); inb16 = 16'($urandom);
    check("busy16_after_start", 32'(busy16), 32'd1);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done16) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, output int lat);
    start8 = 1'b1; ina8 = a; inb8 = b;
    @(negedge clk);
    start8 = 1'b0; ina8 = 8'($urandom); inb8 = 8'($urandom);
    check("busy8_after_start", 32'(busy8), 32'd1);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done8) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic result16(input string tag, input int lat, input logic [15:0] eo,
                          input logic eovf, input logic [15:0] ehi);
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_out"}, 32'(out16), 32'(eo));
    check({tag, "_ovf"}, 32'(ovf16), 32'(eovf));
`ifdef SEQ_MULT_FULL_PRODUCT_EN
    check({tag, "_out_hi"}, 32'(hi16), 32'(ehi));
`else
    if (ehi != ehi) check({tag, "_unused"}, 32'd0, 32'd1);
`endif
    @(negedge clk);
    check({tag, "_done_drop"}, 32'(done16), 32'd0);
    check({tag, "_out_hold"}, 32'(out16), 32'(eo));
    check({tag, "_idle"}, 32'(busy16), 32'd0);
  endtask

  task automatic result8(input string tag, input int lat, input logic [7:0] eo, input logic eovf);
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_out"}, 32'(out8), 32'(eo));
    check({tag, "_ovf"}, 32'(ovf8), 32'(eovf));
    @(negedge clk);
    check({tag, "_done_drop"}, 32'(done8), 32'd0);
    check({tag, "_out_hold"}, 32'(out8), 32'(eo));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec16_t      tv16[6];
    vec8_t       tv8[3];
    int          lat;
    int          e;
    int          ndone;
    logic [15:0] ra, rb;
    logic [7:0]  sa, sb;
    logic [63:0] full;

    tv16[0] = '{16'h0003, 16'h0005, 16'h000F, 16'h0000, 1'b0};
    tv16[1] = '{16'hFFFF, 16'h0002, 16'hFFFE, 16'h0001, 1'b1};
    tv16[2] = '{16'h0100, 16'h0100, 16'h0000, 16'h0001, 1'b1};
    tv16[3] = '{16'h0000, 16'hABCD, 16'h0000, 16'h0000, 1'b0};
    tv16[4] = '{16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b1};
    tv16[5] = '{16'h1234, 16'h0010, 16'h2340, 16'h0001, 1'b1};
    tv8[0]  = '{8'd15, 8'd17, 8'd255, 1'b0};
    tv8[1]  = '{8'd16, 8'd16, 8'd0,   1'b1};
    tv8[2]  = '{8'd0,  8'd255, 8'd0,  1'b0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_busy16", 32'(busy16), 32'd0);
    check("reset_done16", 32'(done16), 32'd0);
    check("reset_out16", 32'(out16), 32'd0);
    check("reset_ovf16", 32'(ovf16), 32'd0);
    check("reset_busy8", 32'(busy8), 32'd0);
    check("reset_out8", 32'(out8), 32'd0);

    for (int i = 0; i < 6; i++) begin
      run16(tv16[i].a, tv16[i].b, lat);
      result16($sformatf("vec16_%0d", i), lat, tv16[i].out, tv16[i].ovf, tv16[i].hi);
    end

    // Start while busy is ignored; then a start in the done cycle is accepted.
    start16 = 1'b1; ina16 = 16'd7; inb16 = 16'd6;
    @(negedge clk);
    start16 = 1'b0;
    @(negedge clk);
    start16 = 1'b1; ina16 = 16'd9; inb16 = 16'd9;
    @(negedge clk);
    start16 = 1'b0; ina16 = 16'd0; inb16 = 16'd0;
    e = 2;
    while (e < 14 && !done16) begin
      @(negedge clk);
      e++;
    end
    check("busy_ignore_latency", 32'(e), 32'd4);
    check("busy_ignore_out", 32'(out16), 32'd42);
    run16(16'd2, 16'd2, lat);
    result16("done_cycle_start", lat, 16'd4, 1'b0, 16'd0);

    // Reset in the middle of an operation abandons it.
    start16 = 1'b1; ina16 = 16'h1234; inb16 = 16'h0010;
    @(negedge clk);
    start16 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(busy16), 32'd0);
    check("midrst_done", 32'(done16), 32'd0);
    check("midrst_out", 32'(out16), 32'd0);
    check("midrst_ovf", 32'(ovf16), 32'd0);
    ndone = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (done16) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 32'd0);
    run16(16'd10, 16'd10, lat);
    result16("after_rst", lat, 16'd100, 1'b0, 16'd0);

    for (int i = 0; i < 3; i++) begin
      run8(tv8[i].a, tv8[i].b, lat);
      result8($sformatf("vec8_%0d", i), lat, tv8[i].out, tv8[i].ovf);
    end

    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      rb = (i % 5 == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      full = 64'(ra) * 64'(rb);
      run16(ra, rb, lat);
      result16($sformatf("rand16_%0d", i), lat, full[15:0], (full >> 16) != 0, full[31:16]);
    end

    for (int i = 0; i < 20; i++) begin
      sa = 8'($urandom);
      sb = 8'($urandom);
      full = 64'(sa) * 64'(sb);
      run8(sa, sb, lat);
      result8($sformatf("rand8_%0d", i), lat, full[7:0], (full >> 8) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
